// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port synchronous RAM between two requesters:
//   port 0 (rv32i core data/fetch) and port 1 (UART boot loader).
//   Each access is sequenced as an address phase (ACCESS) followed by a
//   data phase (ACK) in which the winner sees a one-cycle ack and, for
//   reads, the RAM data on rdata.
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN  defined   -> fixed priority, port 0 wins ties
//                                       (port 1 may starve)
//                          undefined -> round-robin (default)
//
// Ports:
//   clk, resetn            clock (rising edge), async active-low reset
//   req0/req1              access request, held until the matching ack
//   addr0/1, wdata0/1      word address / write data, stable while requesting
//   wmask0/1               byte write enables, all-zero means read
//   ack0/ack1              one-cycle completion pulse
//   rdata                  read data, valid only in the ack cycle
//   mem_addr, mem_wdata    RAM address / write data
//   mem_wmask              RAM byte write enables (ACCESS only)
//   mem_rstrb              RAM read strobe (ACCESS only)
//   mem_rdata              RAM read data, valid the cycle after mem_rstrb
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no access in flight; arbitrate among incoming requests
// ACCESS | winner's address/mask presented to RAM with strobe/enables
// ACK    | ack to winner, read data returned; may chain to other port
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req0,
  input  logic                req1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic [DATA_W/8-1:0] wmask0,
  input  logic [DATA_W/8-1:0] wmask1,
  output logic                ack0,
  output logic                ack1,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_rstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                winner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;

  logic                grant_vld;
  logic                grant_port;
  logic                tie_port;
  logic                in_access;
  logic                in_ack;
  logic                is_read;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign tie_port = 1'b0;
`else
  // Reset value 1 lets port 0 win the very first tie.
  logic last_grant_q;

  assign tie_port = ~last_grant_q;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and grant selection
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_vld  = 1'b0;
    grant_port = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_vld  = 1'b1;
          grant_port = (req0 && req1) ? tie_port : req1;
          state_d    = ACCESS;
        end
      end

      ACCESS: begin
        state_d = ACK;
      end

      ACK: begin
        // The acked port's request is still high this cycle but belongs to
        // the access being completed, so only the other port is considered.
        state_d = IDLE;
`ifdef MEM_ARB_FIXED_PRIO_EN
        // Chaining 0 -> 1 here would bypass port 0's priority; port 1 only
        // gets in from IDLE when port 0 is quiet.
        if (winner_q && req0) begin
          grant_vld  = 1'b1;
          grant_port = 1'b0;
        end
`else
        if (!winner_q && req1) begin
          grant_vld  = 1'b1;
          grant_port = 1'b1;
        end else if (winner_q && req0) begin
          grant_vld  = 1'b1;
          grant_port = 1'b0;
        end
`endif
        if (grant_vld) begin
          state_d = ACCESS;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and latched-request registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      winner_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant_vld) begin
        winner_q <= grant_port;
        addr_q   <= grant_port ? addr1  : addr0;
        wdata_q  <= grant_port ? wdata1 : wdata0;
        wmask_q  <= grant_port ? wmask1 : wmask0;
      end
    end
  end

`ifndef MEM_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= 1'b1;
    end else if (grant_vld) begin
      last_grant_q <= grant_port;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registered state, so strobes/enables are
  // confined to ACCESS and acks to ACK with no combinational path from req.
  // ---------------------------------------------------------------------------
  assign in_access = (state_q == ACCESS);
  assign in_ack    = (state_q == ACK);
  assign is_read   = (wmask_q == '0);

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = in_access ? wmask_q : '0;
  assign mem_rstrb = in_access && is_read;

  assign ack0 = in_ack && !winner_q;
  assign ack1 = in_ack &&  winner_q;

  // RAM data arrives the cycle after the strobe, which is exactly ACK.
  assign rdata = (in_ack && is_read) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              resetn;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [3:0]        wmask0, wmask1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_rstrb;
  logic [DATA_W-1:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] ram [0:4095];
  logic              ram_ready = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .wmask0    (wmask0),
    .wmask1    (wmask1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata)
  );

  // Single-port synchronous RAM: data one cycle after strobe, byte writes.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 4096; i++) ram[i] <= '0;
      ram[12'h010] <= 32'h1234_5678;
      ram_ready    <= 1'b1;
    end else begin
      if (mem_rstrb) mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    req0 = 1'b0;  req1 = 1'b0;
    addr0 = '0;   addr1 = '0;
    wdata0 = '0;  wdata1 = '0;
    wmask0 = '0;  wmask1 = '0;

    // reset held 3 cycles
    repeat (3) @(negedge clk);
    chk("rst_ack0",      32'(ack0),      32'h0);
    chk("rst_ack1",      32'(ack1),      32'h0);
    chk("rst_rstrb",     32'(mem_rstrb), 32'h0);
    chk("rst_wmask",     32'(mem_wmask), 32'h0);
    chk("rst_addr",      32'(mem_addr),  32'h0);
    chk("rst_wdata",     mem_wdata,      32'h0);
    chk("rst_rdata",     rdata,          32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // port 0 read of 0x010
    req0 = 1'b1; addr0 = 12'h010; wmask0 = 4'h0;
    @(negedge clk);
    chk("rd0_rstrb",     32'(mem_rstrb), 32'h1);
    chk("rd0_addr",      32'(mem_addr),  32'h010);
    chk("rd0_wmask",     32'(mem_wmask), 32'h0);
    chk("rd0_ack_early", 32'(ack0),      32'h0);
    @(negedge clk);
    chk("rd0_ack0",      32'(ack0),      32'h1);
    chk("rd0_ack1",      32'(ack1),      32'h0);
    chk("rd0_rdata",     rdata,          32'h1234_5678);
    chk("rd0_rstrb_ack", 32'(mem_rstrb), 32'h0);
    req0 = 1'b0;
    @(negedge clk);
    chk("rd0_ack_once",  32'(ack0),      32'h0);

    // port 1 partial write of 0x020
    req1 = 1'b1; addr1 = 12'h020; wdata1 = 32'hDEAD_BEEF; wmask1 = 4'b0011;
    @(negedge clk);
    chk("wr1_wmask",     32'(mem_wmask), 32'h3);
    chk("wr1_rstrb",     32'(mem_rstrb), 32'h0);
    chk("wr1_wdata",     mem_wdata,      32'hDEAD_BEEF);
    chk("wr1_addr",      32'(mem_addr),  32'h020);
    chk("wr1_ack_early", 32'(ack1),      32'h0);
    @(negedge clk);
    chk("wr1_ack1",      32'(ack1),      32'h1);
    chk("wr1_ack0",      32'(ack0),      32'h0);
    chk("wr1_rdata",     rdata,          32'h0);
    chk("wr1_wmask_ack", 32'(mem_wmask), 32'h0);
    req1 = 1'b0; wmask1 = 4'h0;
    @(negedge clk);
    req0 = 1'b1; addr0 = 12'h020;
    repeat (2) @(negedge clk);
    chk("rb_ack0",       32'(ack0),      32'h1);
    chk("rb_rdata",      rdata,          32'h0000_BEEF);
    req0 = 1'b0;
    @(negedge clk);

    // reset during ACCESS
    req0 = 1'b1; addr0 = 12'h010;
    @(negedge clk);
    chk("mrst_rstrb_pre", 32'(mem_rstrb), 32'h1);
    #2 resetn = 1'b0; req0 = 1'b0;
    #1;
    chk("mrst_rstrb",    32'(mem_rstrb), 32'h0);
    chk("mrst_addr",     32'(mem_addr),  32'h0);
    chk("mrst_ack0_now", 32'(ack0),      32'h0);
    @(negedge clk);
    chk("mrst_ack0",     32'(ack0),      32'h0);
    chk("mrst_ack1",     32'(ack1),      32'h0);
    resetn = 1'b1;
    @(negedge clk);
    chk("mrst_idle_ack", 32'(ack0),      32'h0);
    chk("mrst_idle_strb", 32'(mem_rstrb), 32'h0);
    req0 = 1'b1;
    @(negedge clk);
    chk("mrst_re_rstrb", 32'(mem_rstrb), 32'h1);
    @(negedge clk);
    chk("mrst_re_ack0",  32'(ack0),      32'h1);
    chk("mrst_re_rdata", rdata,          32'h1234_5678);
    req0 = 1'b0;
    @(negedge clk);

    // request dropped during ACCESS still completes
    req0 = 1'b1; addr0 = 12'h020;
    @(negedge clk);
    chk("drop_rstrb",    32'(mem_rstrb), 32'h1);
    req0 = 1'b0;
    @(negedge clk);
    chk("drop_ack0",     32'(ack0),      32'h1);
    chk("drop_rdata",    rdata,          32'h0000_BEEF);
    @(negedge clk);
    chk("drop_ack_once", 32'(ack0),      32'h0);
    chk("drop_idle",     32'(mem_rstrb), 32'h0);
    @(negedge clk);
    chk("drop_idle2",    32'(mem_rstrb), 32'h0);

    // tie with last grant = port 0: port 1 goes first
    req0 = 1'b1; req1 = 1'b1; addr0 = 12'h010; addr1 = 12'h020;
    wmask0 = 4'h0; wmask1 = 4'h0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("rr_ack0_c%0d", k), 32'(ack0), 32'(k == 4));
      chk($sformatf("rr_ack1_c%0d", k), 32'(ack1), 32'(k == 2));
      if (k == 2) chk("rr_rdata1", rdata, 32'h0000_BEEF);
      if (k == 4) chk("rr_rdata0", rdata, 32'h1234_5678);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("rr_idle_ack0",  32'(ack0),      32'h0);
    chk("rr_idle_ack1",  32'(ack1),      32'h0);

    // fresh reset, then both held: grants 0,1,0,1 with acks every 2 cycles
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("both_ack0_c%0d", k), 32'(ack0), 32'((k % 4) == 2));
      chk($sformatf("both_ack1_c%0d", k), 32'(ack1), 32'((k % 4) == 0));
      if ((k % 4) == 2) chk($sformatf("both_rdata0_c%0d", k), rdata, 32'h1234_5678);
      if ((k % 4) == 0) chk($sformatf("both_rdata1_c%0d", k), rdata, 32'h0000_BEEF);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("both_end_ack0", 32'(ack0),      32'h0);
    chk("both_end_strb", 32'(mem_rstrb), 32'h0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
